psum_adder_sched: RTL
=====================

// Module: psum_adder_sched
// PURPOSE
//  Sequencer for the binarized psum adder tree, one ofmap tile per run.
//  Latches the layer config and walks the output pixels in raster order.
//  Issues one psum vector plus its ofmap BRAM address per accepted upstream beat.
//  Tracks results in flight through the adder pipeline and signals done once all have returned.
//  Sits between the PE array (psum source) and psum_adder; also drives the adder's config ports.
// PARAMETERS
//  OFMAPS_BRAM_ADDR_WIDTH  12  ofmap BRAM address width
//  ADDER_LATENCY           10  cycles from adder i_valid to o_valid
//  OUTST_WIDTH             5   outstanding-counter width (must hold ADDER_LATENCY+1)
// PORTS
//  clk             in   1    clock
//  rst             in   1    synchronous, active-high reset
//  start           in   1    1-cycle pulse; begins a run (honoured only in IDLE)
//  abort           in   1    stop issuing; drain in-flight results, then finish
//  cfg_in_channel  in   8    input channels (latched at start)
//  cfg_kernel_size in   3    kernel size k (latched at start)
//  cfg_ofmap_h     in   8    ofmap rows (latched at start)
//  cfg_ofmap_w     in   8    ofmap cols (latched at start)
//  cfg_base_addr   in   AW   ofmap BRAM base address (latched at start)
//  psum_valid      in   1    upstream psum vector available
//  psum_ready      out  1    controller accepts the psum vector this cycle
//  wr_stall        in   1    downstream writer back-pressure; blocks new issues
//  adder_in_channel out 8    latched cfg_in_channel, sent to adder
//  adder_kernel_size out 3   latched cfg_kernel_size, sent to adder
//  adder_i_valid   out  1    adder i_valid
//  adder_addr      out  AW   adder address_in
//  adder_o_valid   in   1    adder o_valid (result returned)
//  busy            out  1    high from LOAD through DRAIN
//  done            out  1    1-cycle pulse at run end
//  cfg_err         out  1    sticky until next start; set on zero h/w/k/in_channel
// BEHAVIOUR
//  Reset: state=IDLE; psum_ready, adder_i_valid, busy, done, cfg_err = 0.
//    Reset also clears adder_addr, adder_in_channel, adder_kernel_size and all counters.
//  FSM: IDLE -start-> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
//    LOAD (1 cycle): latch cfg; clear row/col/outstanding counters; clear cfg_err.
//      If any of h, w, k or in_channel is 0: set cfg_err and go straight to DONE (no issues).
//    RUN: psum_ready = !wr_stall && outstanding < ADDER_LATENCY+1.
//      An issue occurs when psum_valid && psum_ready.
//      adder_i_valid is combinational: psum_valid && psum_ready (psum passes straight to the adder).
//      adder_addr is registered and holds the address of the pixel being issued.
//        Address starts at cfg_base_addr and is incremented by an address counter (no multiplier).
//        Address wraps modulo 2^AW.
//      col advances on each issue; when col==w-1 it wraps to 0 and row advances.
//      Issue of pixel (h-1, w-1), or abort, moves RUN to DRAIN.
//    DRAIN: psum_ready = 0. Leave when outstanding==0 (checked after this cycle's update).
//    DONE (1 cycle): done=1, busy=0; next state IDLE.
//  Outstanding counter: +1 on issue, -1 on adder_o_valid.
//    Issue and return in the same cycle leave it unchanged.
//    adder_o_valid arriving while outstanding==0 is ignored (counter saturates at 0).
//  start outside IDLE is ignored. abort in IDLE, LOAD or DONE is ignored.
//  rst mid-run returns to IDLE next edge; results still in the adder are not tracked.
//  adder_in_channel and adder_kernel_size stay stable from LOAD until the next LOAD.
//  Latency: first adder_i_valid is at the earliest 2 cycles after start (LOAD, then RUN).
//    done is 1 cycle after the DRAIN exit condition holds.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/LOAD/RUN/DRAIN/DONE), ADDER_LATENCY, ofmap address width.
//  Sub-module: psum_raster_cnt, the row/col counter with wrap and last flag plus the address incrementer.
//  FSM and outstanding counter live in the top.
// TESTING
//  h=2,w=3,base=0x010,k=3,in_ch=64, psum_valid held 1:
//    adder_addr 0x010..0x015 on 6 consecutive cycles.
//    Return 6 adder_o_valid 10 cycles after each issue; done pulses 1 cycle after the last return.
//  Same config with wr_stall high for 4 cycles mid-RUN: no issue during the stall; address sequence unbroken.
//  k=0: cfg_err=1 and done 2 cycles after start, zero adder_i_valid.
//  abort after 3 issues with returns delayed: no further issues; done only after 3 returns.
//  base=0xFFE,h=1,w=4: addresses 0xFFE,0xFFF,0x000,0x001.
//  rst asserted in DRAIN: next cycle busy=0, psum_ready=0, no done pulse.
//  start pulsed during RUN: ignored, sequence unchanged.

Source files
------------

// File: rtl/psum_adder_sched_pkg.sv
// Shared definitions for the psum adder-tree sequencer.
//   - FSM state encoding for psum_adder_sched
//   - default ofmap BRAM address width, adder latency and outstanding-counter width
package psum_adder_sched_pkg;

    localparam int OFMAP_AW  = 12;  // ofmap BRAM address width
    localparam int ADDER_LAT = 10;  // adder i_valid -> o_valid latency
    localparam int OUTST_W   = 5;   // must hold ADDER_LAT + 1

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/psum_raster_cnt.sv
// Raster-order pixel walker for one ofmap tile.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart at pixel (0,0), address = base
//   base     : tile base address, sampled on clear
//   adv      : advance to the next pixel
//   h, w     : tile rows / cols (non-zero while advancing)
//   addr     : address of the current pixel (wraps modulo 2^AW)
//   last     : current pixel is (h-1, w-1)
module psum_raster_cnt
    import psum_adder_sched_pkg::*;
#(
    parameter int AW = OFMAP_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [AW-1:0] base,
    input  logic          adv,
    input  logic [7:0]    h,
    input  logic [7:0]    w,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [7:0] row;
    logic [7:0] col;
    logic       col_last;

    assign col_last = (col == w - 8'd1);
    assign last     = col_last && (row == h - 8'd1);

    // Address is a running increment rather than base + row*w + col.
    always_ff @(posedge clk) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (clear) begin
            row  <= '0;
            col  <= '0;
            addr <= base;
        end else if (adv) begin
            addr <= addr + AW'(1);
            if (col_last) begin
                col <= '0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/psum_adder_sched.sv
// Sequencer for the binarized psum adder tree, one ofmap tile per run.
//   start/abort           : run control (start honoured in IDLE, abort in RUN)
//   cfg_*                 : layer config, latched in LOAD
//   psum_valid/psum_ready : upstream psum handshake; an accepted beat is issued
//   wr_stall              : downstream back-pressure, blocks new issues
//   adder_*               : adder config, i_valid, address and returned o_valid
//   busy/done/cfg_err     : status (busy LOAD..DRAIN, done 1-cycle, cfg_err sticky)
module psum_adder_sched
    import psum_adder_sched_pkg::*;
#(
    parameter int OFMAPS_BRAM_ADDR_WIDTH = OFMAP_AW,
    parameter int ADDER_LATENCY          = ADDER_LAT,
    parameter int OUTST_WIDTH            = OUTST_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [7:0]                        cfg_in_channel,
    input  logic [2:0]                        cfg_kernel_size,
    input  logic [7:0]                        cfg_ofmap_h,
    input  logic [7:0]                        cfg_ofmap_w,
    input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic                              psum_valid,
    output logic                              psum_ready,
    input  logic                              wr_stall,
    output logic [7:0]                        adder_in_channel,
    output logic [2:0]                        adder_kernel_size,
    output logic                              adder_i_valid,
    output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] adder_addr,
    input  logic                              adder_o_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err
);

    localparam logic [OUTST_WIDTH-1:0] OUTST_MAX = OUTST_WIDTH'(ADDER_LATENCY + 1);
    localparam logic [OUTST_WIDTH-1:0] OUTST_ONE = OUTST_WIDTH'(1);

    state_t                   state, state_nxt;
    logic [7:0]               h_q, w_q;
    logic [OUTST_WIDTH-1:0]   outst, outst_nxt;
    logic                     issue;
    logic                     ret;
    logic                     last_pix;
    logic                     zero_cfg;

    assign issue         = psum_valid && psum_ready;
    assign adder_i_valid = issue;
    // A return with nothing outstanding is stale (e.g. after a reset) and dropped.
    assign ret           = adder_o_valid && (outst != '0);
    assign zero_cfg      = (cfg_ofmap_h == 8'd0) || (cfg_ofmap_w == 8'd0) ||
                           (cfg_kernel_size == 3'd0) || (cfg_in_channel == 8'd0);

    always_comb begin
        outst_nxt = outst;
        if (issue && !ret)
            outst_nxt = outst + OUTST_ONE;
        else if (!issue && ret)
            outst_nxt = outst - OUTST_ONE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = zero_cfg ? ST_DONE : ST_RUN;
            ST_RUN:   if ((issue && last_pix) || abort) state_nxt = ST_DRAIN;
            ST_DRAIN: if (outst_nxt == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        psum_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_LOAD:  busy = 1'b1;
            ST_RUN: begin
                busy       = 1'b1;
                psum_ready = !wr_stall && (outst < OUTST_MAX);
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adder_in_channel  <= '0;
            adder_kernel_size <= '0;
            h_q               <= '0;
            w_q               <= '0;
            cfg_err           <= 1'b0;
            outst             <= '0;
        end else if (state == ST_LOAD) begin
            adder_in_channel  <= cfg_in_channel;
            adder_kernel_size <= cfg_kernel_size;
            h_q               <= cfg_ofmap_h;
            w_q               <= cfg_ofmap_w;
            cfg_err           <= zero_cfg;
            outst             <= '0;
        end else begin
            outst             <= outst_nxt;
        end
    end

    psum_raster_cnt #(
        .AW (OFMAPS_BRAM_ADDR_WIDTH)
    ) u_raster (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_LOAD),
        .base  (cfg_base_addr),
        .adv   (issue),
        .h     (h_q),
        .w     (w_q),
        .addr  (adder_addr),
        .last  (last_pix)
    );

endmodule
